setting_vga_scan: RTL
=====================

// Module: setting_vga_scan
// PURPOSE
//  Downstream consumer of the setting screen memory: generates 640x480@60 VGA timing, drives
//  ram_addr_x/ram_addr_y into the setting block and turns the returned ram_data into RGB444.
//  Screen memory is 160x120; each memory pixel covers a 4x4 block of screen pixels.
//  One pixel period of pipeline; sync, blank and colour leave the block aligned.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48  (line total 800)
//  V_ACTIVE 480 visible lines;  V_FP 10;  V_SYNC 2;  V_BP 33  (frame total 525)
//  PIX_DIV 4      clk cycles per pixel (100 MHz clk -> 25 MHz pixel tick)
//  SCALE_SHIFT 2  screen-to-memory coordinate shift (4x4 block per memory pixel)
//  RAM_LAT 1      clk cycles from ram_addr_* change to valid ram_data; must be < PIX_DIV
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-low (0 = reset)
//  ram_data     in   16  pixel from setting memory; [11:8]=R [7:4]=G [3:0]=B, [15:12] ignored
//  ram_addr_x   out  8   memory column = h_cnt >> SCALE_SHIFT (0..159)
//  ram_addr_y   out  8   memory row    = v_cnt >> SCALE_SHIFT (0..119)
//  hsync        out  1   horizontal sync, active-low
//  vsync        out  1   vertical sync, active-low
//  vga_r/g/b    out  4 each  colour, forced 0 outside the active area
//  active       out  1   1 while the emitted pixel is in the visible area
//  frame_start  out  1   one-clk pulse when pixel (0,0) is emitted
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge): div_cnt=0, h_cnt=0, v_cnt=0, ram_addr_x/y=0, hsync=1, vsync=1,
//    vga_r/g/b=0, active=0, frame_start=0. Reset mid-frame restarts at (0,0) on the next tick.
//  - Tick: div_cnt counts 0..PIX_DIV-1 and wraps; tick=1 in the cycle div_cnt==PIX_DIV-1.
//  - Counters advance only on tick: h_cnt 0..799, at 799 wraps to 0 and v_cnt increments;
//    v_cnt 0..524, at 524 with h_cnt=799 both wrap to 0.
//  - Stage A (on tick): register ram_addr_x/y from next (h,v); in blanking hold both at 0.
//    Also register hs_a, vs_a, act_a for that pixel:
//    hs_a=0 for h in [656,751]; vs_a=0 for v in [490,491]; act_a = h<640 && v<480.
//  - Stage B (on the following tick, >= PIX_DIV clk after address change, so RAM_LAT satisfied):
//    hsync<=hs_a, vsync<=vs_a, active<=act_a, vga_{r,g,b}<= act_a ? ram_data fields : 0.
//  - Net latency: counter value (h,v) appears on outputs exactly one pixel period (PIX_DIV clk)
//    after it is addressed; all outputs change only on tick edges, held otherwise.
//  - frame_start: 1 for exactly one clk, the cycle stage B loads pixel (0,0); else 0.
//  - Address width: 640>>2=160, 480>>2=120, fits 8 bits, no truncation; ram_data never
//    sampled outside the active area.
//  - No backpressure: ram_data is assumed valid RAM_LAT clk after any address change.
// TESTING
//  1 Hold rst=0 10 clk, release -> all outputs at reset values; first tick 4 clk after release.
//  2 Free-run one line -> hsync low for exactly 96 ticks (384 clk), starting at emitted h=656;
//    line period 3200 clk.
//  3 Free-run two frames -> frame_start pulses 1,680,000 clk apart (800*525*4); vsync low for
//    exactly 2 lines (6400 clk) starting at emitted v=490.
//  4 Address map: at h=4..7,v=8 -> ram_addr_x=1, ram_addr_y=2; at h=639 -> ram_addr_x=159;
//    at h=640..799 -> ram_addr_x=0, ram_addr_y=0.
//  5 RAM model returning 16'hFA53 (1 clk latency) -> active pixels give r=A g=5 b=3;
//    blank pixels give r=g=b=0 and active=0 even with ram_data=16'hFFFF.
//  6 Assert rst=0 for 1 clk at h=300,v=200 -> next outputs restart from (0,0), frame_start
//    pulses one pixel period after the first post-reset tick; no stale colour emitted.

Source files
------------

// File: rtl/setting_vga_scan.sv
// VGA scan generator for the setting screen: pixel-tick timing, memory addressing
// (one memory pixel per 4x4 screen block) and a two-stage address/colour pipeline.
module setting_vga_scan #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int PIX_DIV     = 4,
   parameter int SCALE_SHIFT = 2,
   parameter int RAM_LAT     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ram_data,
   output logic [7:0]  ram_addr_x,
   output logic [7:0]  ram_addr_y,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        active,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(PIX_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          tick;
   logic          vis_c;
   logic          hs_c;
   logic          vs_c;
   logic          first_c;
   logic [7:0]    addr_x_c;
   logic [7:0]    addr_y_c;

   // Stage A: attributes of the pixel whose address is currently on ram_addr_*
   logic          hs_a;
   logic          vs_a;
   logic          act_a;
   logic          first_a;

   logic          unused_ram_hi;
   assign unused_ram_hi = ^ram_data[15:12];

   // Stage B reads ram_data one full pixel period after the address moved,
   // so any RAM_LAT below PIX_DIV is covered without extra delay stages.
   always_comb begin
      tick     = (div_cnt == DIV_LAST);
      vis_c    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_c     = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
      vs_c     = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
      first_c  = (h_cnt == '0) && (v_cnt == '0);
      addr_x_c = 8'd0;
      addr_y_c = 8'd0;
      if (vis_c) begin
         addr_x_c = 8'(h_cnt >> SCALE_SHIFT);
         addr_y_c = 8'(v_cnt >> SCALE_SHIFT);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ram_addr_x <= 8'd0;
         ram_addr_y <= 8'd0;
         hs_a       <= 1'b1;
         vs_a       <= 1'b1;
         act_a      <= 1'b0;
         first_a    <= 1'b0;
      end else if (tick) begin
         ram_addr_x <= addr_x_c;
         ram_addr_y <= addr_y_c;
         hs_a       <= hs_c;
         vs_a       <= vs_c;
         act_a      <= vis_c;
         first_a    <= first_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         active      <= 1'b0;
         vga_r       <= 4'd0;
         vga_g       <= 4'd0;
         vga_b       <= 4'd0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (tick) begin
            hsync       <= hs_a;
            vsync       <= vs_a;
            active      <= act_a;
            vga_r       <= act_a ? ram_data[11:8] : 4'd0;
            vga_g       <= act_a ? ram_data[7:4]  : 4'd0;
            vga_b       <= act_a ? ram_data[3:0]  : 4'd0;
            frame_start <= first_a;
         end
      end
   end

endmodule
